// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: condition codes, FSM states and status bit positions.
package branch_pkg;

    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    localparam int ST_N = 2;
    localparam int ST_V = 1;
    localparam int ST_Z = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/branch_unit_cond_eval.sv
// Combinational branch-condition decoder; codes 101-111 are reported as reserved and never taken.
module cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [2:0] i_status,
    output logic       o_taken,
    output logic       o_reserved
);

    logic w_lt;

    assign w_lt = i_status[ST_N] ^ i_status[ST_V];

    always_comb begin
        o_taken    = 1'b0;
        o_reserved = 1'b0;
        case (i_cond)
            COND_B:   o_taken = 1'b1;
            COND_BEQ: o_taken = i_status[ST_Z];
            COND_BNE: o_taken = ~i_status[ST_Z];
            COND_BLT: o_taken = w_lt;
            COND_BLE: o_taken = w_lt | i_status[ST_Z];
            default:  o_reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: latches ALU status and resolves branches via an IDLE/EVAL/DONE handshake.
// Optional feature macro: BRANCH_ERR_EN adds the err output flagging reserved condition codes.
module branch_unit
    import branch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int OFF_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       status_in,
    input  logic             load_status,
    input  logic             start,
    input  logic [2:0]       cond,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  pc_in,
    output logic             ready,
    output logic             done,
    output logic             taken,
    output logic [PC_W-1:0]  pc_out,
    output logic [2:0]       status_out
`ifdef BRANCH_ERR_EN
    ,
    output logic             err
`endif
);

    state_t           r_state;
    logic [2:0]       r_status;
    logic [2:0]       r_snap;
    logic [2:0]       r_cond;
    logic [OFF_W-1:0] r_offset;
    logic [PC_W-1:0]  r_pc;
    logic             r_ready;
    logic             r_done;
    logic             r_taken;
    logic [PC_W-1:0]  r_pc_out;

    logic             w_taken;
    logic             w_reserved;
    logic [PC_W-1:0]  w_target;

    cond_eval u_cond_eval (
        .i_cond     (r_cond),
        .i_status   (r_snap),
        .o_taken    (w_taken),
        .o_reserved (w_reserved)
    );

    assign w_target = r_pc + {{(PC_W-OFF_W){r_offset[OFF_W-1]}}, r_offset};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= 3'b000;
        end else if (load_status) begin
            r_status <= status_in;
        end
    end

    // The snapshot taken on accept decouples the evaluation from later status loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_taken  <= 1'b0;
            r_pc_out <= '0;
            r_snap   <= 3'b000;
            r_cond   <= 3'b000;
            r_offset <= '0;
            r_pc     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_cond   <= cond;
                        r_offset <= offset;
                        r_pc     <= pc_in;
                        r_snap   <= r_status;
                        r_ready  <= 1'b0;
                        r_state  <= EVAL;
                    end
                end
                EVAL: begin
                    r_taken  <= w_taken & ~w_reserved;
                    r_pc_out <= (w_taken & ~w_reserved) ? w_target : r_pc;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (r_state == EVAL) begin
            r_err <= w_reserved;
        end
    end

    assign err = r_err;
`endif

    assign ready      = r_ready;
    assign done       = r_done;
    assign taken      = r_taken;
    assign pc_out     = r_pc_out;
    assign status_out = r_status;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit; err checks are compiled in with BRANCH_ERR_EN.
module tb_branch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] status_in;
    logic       load_status;
    logic       start;
    logic [2:0] cond;
    logic [7:0] offset;
    logic [8:0] pc_in;
    logic       ready;
    logic       done;
    logic       taken;
    logic [8:0] pc_out;
    logic [2:0] status_out;
`ifdef BRANCH_ERR_EN
    logic       err;
`endif

    int checks   = 0;
    int failures = 0;
    int donePulses = 0;

    branch_unit #(.PC_W(9), .OFF_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .status_in   (status_in),
        .load_status (load_status),
        .start       (start),
        .cond        (cond),
        .offset      (offset),
        .pc_in       (pc_in),
        .ready       (ready),
        .done        (done),
        .taken       (taken),
        .pc_out      (pc_out),
        .status_out  (status_out)
`ifdef BRANCH_ERR_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) donePulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadStatus(input logic [2:0] s);
        status_in   = s;
        load_status = 1'b1;
        step();
        load_status = 1'b0;
    endtask

    task automatic waitReady();
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_ready timeout ready=%b", ready);
        end
    endtask

    // Accept edge, then EVAL cycle, then results sampled in the DONE cycle.
    task automatic runBranch(input string name, input logic [2:0] c, input logic [7:0] off,
                             input logic [8:0] pc, input logic expTaken, input logic [8:0] expPc);
        waitReady();
        cond = c; offset = off; pc_in = pc; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_eval_state ready=%b done=%b exp ready=0 done=0", name, ready, done);
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_done got=%b exp=1", name, done);
        end
        checks++;
        if (taken !== expTaken) begin
            failures++;
            $display("[TB] FAIL %s_taken got=%b exp=%b", name, taken, expTaken);
        end
        checks++;
        if (pc_out !== expPc) begin
            failures++;
            $display("[TB] FAIL %s_pc_out got=%h exp=%h", name, pc_out, expPc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; load_status = 1'b0;
        status_in = 3'b000; cond = 3'b000; offset = 8'h00; pc_in = 9'h000;
        step(); step();
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || taken !== 1'b0 || pc_out !== 9'h000 || status_out !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_values ready=%b done=%b taken=%b pc_out=%h status=%b exp 1 0 0 000 000",
                     ready, done, taken, pc_out, status_out);
        end
`ifdef BRANCH_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_err got=%b exp=0", err);
        end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_beq_wrap();
        loadStatus(3'b001);
        checks++;
        if (status_out !== 3'b001) begin
            failures++;
            $display("[TB] FAIL status_load got=%b exp=001", status_out);
        end
        runBranch("beq_wrap", 3'b001, 8'h05, 9'h1FE, 1'b1, 9'h003);
        step();
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL beq_return_idle ready=%b done=%b exp ready=1 done=0", ready, done);
        end
    endtask

    task automatic test_reset_mid_eval();
        int p0;
        loadStatus(3'b101);
        waitReady();
        cond = 3'b000; offset = 8'h10; pc_in = 9'h050; start = 1'b1;
        step();
        start = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || status_out !== 3'b000 || pc_out !== 9'h000) begin
            failures++;
            $display("[TB] FAIL reset_mid_eval ready=%b done=%b status=%b pc_out=%h exp 1 0 000 000",
                     ready, done, status_out, pc_out);
        end
        p0 = donePulses;
        step();
        reset = 1'b0;
        repeat (5) step();
        checks++;
        if (donePulses !== p0) begin
            failures++;
            $display("[TB] FAIL reset_no_done got=%0d pulses exp=0", donePulses - p0);
        end
    endtask

    task automatic test_blt();
        loadStatus(3'b110);
        runBranch("blt_not", 3'b011, 8'hF0, 9'h010, 1'b0, 9'h010);
        loadStatus(3'b100);
        runBranch("blt_taken", 3'b011, 8'hF0, 9'h010, 1'b1, 9'h000);
        loadStatus(3'b001);
        runBranch("ble_z", 3'b100, 8'h7F, 9'h0F0, 1'b1, 9'h16F);
    endtask

    task automatic test_same_edge_hazard();
        loadStatus(3'b000);
        waitReady();
        status_in = 3'b001; load_status = 1'b1;
        cond = 3'b001; offset = 8'h10; pc_in = 9'h040; start = 1'b1;
        step();
        start = 1'b0; load_status = 1'b0;
        checks++;
        if (status_out !== 3'b001) begin
            failures++;
            $display("[TB] FAIL hazard_status got=%b exp=001", status_out);
        end
        step();
        checks++;
        if (done !== 1'b1 || taken !== 1'b0 || pc_out !== 9'h040) begin
            failures++;
            $display("[TB] FAIL hazard_result done=%b taken=%b pc_out=%h exp 1 0 040", done, taken, pc_out);
        end
    endtask

    task automatic test_load_during_eval();
        waitReady();
        cond = 3'b010; offset = 8'h02; pc_in = 9'h100; start = 1'b1;
        step();
        start = 1'b0;
        status_in = 3'b000; load_status = 1'b1;
        step();
        load_status = 1'b0;
        checks++;
        if (done !== 1'b1 || taken !== 1'b0 || pc_out !== 9'h100) begin
            failures++;
            $display("[TB] FAIL eval_load result done=%b taken=%b pc_out=%h exp 1 0 100", done, taken, pc_out);
        end
        checks++;
        if (status_out !== 3'b000) begin
            failures++;
            $display("[TB] FAIL eval_load_status got=%b exp=000", status_out);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        loadStatus(3'b001);
        waitReady();
        p0 = donePulses;
        cond = 3'b001; offset = 8'h01; pc_in = 9'h010; start = 1'b1;
        step();
        cond = 3'b000; offset = 8'h22; pc_in = 9'h1AA;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_ready_t1 got=%b exp=0", ready);
        end
        step();
        checks++;
        if (ready !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_t2 ready=%b done=%b exp ready=0 done=1", ready, done);
        end
        step();
        start = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_ready_t3 got=%b exp=1", ready);
        end
        repeat (5) step();
        checks++;
        if (donePulses - p0 !== 1) begin
            failures++;
            $display("[TB] FAIL busy_pulses got=%0d exp=1", donePulses - p0);
        end
        checks++;
        if (pc_out !== 9'h011 || taken !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_hold taken=%b pc_out=%h exp 1 011", taken, pc_out);
        end
    endtask

    task automatic test_reserved();
        runBranch("reserved", 3'b110, 8'h40, 9'h020, 1'b0, 9'h020);
`ifdef BRANCH_ERR_EN
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reserved_err got=%b exp=1", err);
        end
`endif
        runBranch("b_negwrap", 3'b000, 8'h80, 9'h005, 1'b1, 9'h185);
`ifdef BRANCH_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_clear got=%b exp=0", err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_beq_wrap();
        test_reset_mid_eval();
        test_blt();
        test_same_edge_hazard();
        test_load_during_eval();
        test_back_to_back();
        test_reserved();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
